// File: rtl/qdi_1of2_pkg.sv
// Shared definitions for 1-of-2 dual-rail QDI channels: handshake states,
// rail encodings and the bit-to-rail mapping.
`timescale 1ns/1ps
package qdi_1of2_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        NULL = 2'd2
    } tx_state_t;

    localparam logic [1:0] RAIL_NEUTRAL = 2'b00;
    localparam logic [1:0] RAIL_ZERO    = 2'b01;
    localparam logic [1:0] RAIL_ONE     = 2'b10;

    function automatic logic [1:0] bit2rail(input logic b);
        return b ? RAIL_ONE : RAIL_ZERO;
    endfunction

endpackage

// File: rtl/qdi_sync.sv
// Multi-flop synchronizer for a single asynchronous level, cleared by an
// asynchronous active-low reset.
`timescale 1ns/1ps
module qdi_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/sync2qdi_tx_1of2.sv
// Clocked-to-QDI token source: buffers bits from a valid/ready port and
// emits each one as a 1-of-2 dual-rail token on a 4-phase Tx/Txe channel.
`timescale 1ns/1ps
module sync2qdi_tx_1of2
    import qdi_1of2_pkg::*;
#(
    parameter int DEPTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 16
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_data,
    output logic [1:0]       Tx,
    input  logic             Txe,
    output logic             busy,
    output logic [CNT_W-1:0] tok_sent
);

    localparam int AW = $clog2(DEPTH);

    logic             txe_s;
    logic             push;
    logic             pop;

    logic [DEPTH-1:0] mem_q,    mem_d;
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             empty_q,  empty_d;
    logic             ready_q,  ready_d;
    tx_state_t        state_q,  state_d;
    logic [1:0]       tx_q,     tx_d;
    logic [CNT_W-1:0] tok_q,    tok_d;

    qdi_sync #(
        .STAGES (SYNC_STAGES)
    ) u_txe_sync (
        .clk   (CLK),
        .rst_n (RESET),
        .d     (Txe),
        .q     (txe_s)
    );

    // ready_q is the registered complement of full; it resets low so the
    // producer sees no space until the first edge after reset release.
    always_comb begin
        push     = in_valid & ready_q;
        pop      = (state_q == IDLE) & ~empty_q & txe_s;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            mem_d[wr_ptr_q[AW-1:0]] = in_data;
            wr_ptr_d                = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        empty_d = (wr_ptr_d == rd_ptr_d);
        ready_d = ~((wr_ptr_d[AW] != rd_ptr_d[AW]) &&
                    (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]));
    end

    always_comb begin
        state_d = state_q;
        tx_d    = tx_q;
        tok_d   = tok_q;
        case (state_q)
            IDLE: begin
                if (pop) begin
                    tx_d    = bit2rail(mem_q[rd_ptr_q[AW-1:0]]);
                    state_d = DATA;
                end
            end
            DATA: begin
                if (!txe_s) begin
                    tx_d    = RAIL_NEUTRAL;
                    tok_d   = tok_q + 1'b1;
                    state_d = NULL;
                end
            end
            NULL: begin
                if (txe_s) begin
                    state_d = IDLE;
                end
            end
            default: begin
                tx_d    = RAIL_NEUTRAL;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            empty_q  <= 1'b1;
            ready_q  <= 1'b0;
            state_q  <= IDLE;
            tx_q     <= RAIL_NEUTRAL;
            tok_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            empty_q  <= empty_d;
            ready_q  <= ready_d;
            state_q  <= state_d;
            tx_q     <= tx_d;
            tok_q    <= tok_d;
        end
    end

    assign in_ready = ready_q;
    assign Tx       = tx_q;
    assign busy     = ~empty_q | (state_q != IDLE);
    assign tok_sent = tok_q;

endmodule

// File: tb/tb_sync2qdi_tx_1of2.sv
// Directed bench for sync2qdi_tx_1of2: a 4-phase receiver model, a rail
// monitor and hand-computed expected token sequences.
`timescale 1ns/1ps
module tb_sync2qdi_tx_1of2;

    localparam int DEPTH       = 8;
    localparam int SYNC_STAGES = 2;
    localparam int CNT_W       = 16;

    logic             CLK;
    logic             RESET;
    logic             in_valid;
    logic             in_ready;
    logic             in_data;
    logic [1:0]       Tx;
    logic             Txe;
    logic             busy;
    logic [CNT_W-1:0] tok_sent;

    logic       rx_auto;
    logic       rx_txe;
    logic       manual_txe;
    int         rx_cnt;
    logic [1:0] prev_tx;
    logic [1:0] log_q[$];
    int         illegal_cnt;
    int         skip_cnt;
    int         checks_total;
    int         checks_passed;

    assign Txe = rx_auto ? rx_txe : manual_txe;

    sync2qdi_tx_1of2 #(
        .DEPTH       (DEPTH),
        .SYNC_STAGES (SYNC_STAGES),
        .CNT_W       (CNT_W)
    ) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .Tx       (Tx),
        .Txe      (Txe),
        .busy     (busy),
        .tok_sent (tok_sent)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Receiver: drops Txe 3 cycles after seeing data, raises it 3 cycles after neutral.
    always @(negedge CLK) begin
        if (!RESET || !rx_auto) begin
            rx_txe = 1'b1;
            rx_cnt = 0;
        end else if ((Tx != 2'b00 && rx_txe) || (Tx == 2'b00 && !rx_txe)) begin
            rx_cnt = rx_cnt + 1;
            if (rx_cnt >= 3) begin
                rx_txe = ~rx_txe;
                rx_cnt = 0;
            end
        end else begin
            rx_cnt = 0;
        end
    end

    // Rail monitor: logs each launched token and counts protocol violations.
    always @(negedge CLK) begin
        if (!RESET) begin
            prev_tx = 2'b00;
        end else begin
            if (Tx == 2'b11) illegal_cnt = illegal_cnt + 1;
            if (prev_tx != 2'b00 && Tx != 2'b00 && Tx != prev_tx) skip_cnt = skip_cnt + 1;
            if (prev_tx == 2'b00 && Tx != 2'b00) log_q.push_back(Tx);
            prev_tx = Tx;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks_total = checks_total + 1;
        if (actual === expected) begin
            checks_passed = checks_passed + 1;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic bit_val);
        int wait_cycles;
        wait_cycles = 0;
        in_valid = 1'b1;
        in_data  = bit_val;
        while (!in_ready && wait_cycles < 300) begin
            @(negedge CLK);
            wait_cycles++;
        end
        checkOutput("push accepted in time", (wait_cycles < 300) ? 32'd1 : 32'd0, 32'd1);
        @(negedge CLK);
        in_valid = 1'b0;
    endtask

    task automatic waitIdle();
        int n;
        n = 0;
        while (busy && n < 600) begin
            @(negedge CLK);
            n++;
        end
        checkOutput("drained to idle", (n < 600) ? 32'd1 : 32'd0, 32'd1);
    endtask

    logic       stream_bits [8]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [1:0] stream_rails[8]  = '{2'b10, 2'b01, 2'b10, 2'b10, 2'b01, 2'b01, 2'b10, 2'b01};
    logic       full_bits   [11] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [1:0] full_rails  [11] = '{2'b10, 2'b10, 2'b01, 2'b10, 2'b01, 2'b01, 2'b10, 2'b01,
                                     2'b10, 2'b10, 2'b01};

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no finish, expected finish before 200000 ns");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int         leak;
        int         edges;
        int         n;
        int         base;
        logic [1:0] got;

        checks_total  = 0;
        checks_passed = 0;
        illegal_cnt   = 0;
        skip_cnt      = 0;
        rx_auto       = 1'b0;
        manual_txe    = 1'b1;
        RESET         = 1'b0;
        in_valid      = 1'b1;
        in_data       = 1'b1;

        // Test 1: reset holds everything quiet despite in_valid and a toggling Txe
        repeat (6) begin
            @(negedge CLK);
            manual_txe = ~manual_txe;
            checkOutput("reset Tx", {30'd0, Tx}, 32'd0);
            checkOutput("reset in_ready", {31'd0, in_ready}, 32'd0);
            checkOutput("reset tok_sent", {16'd0, tok_sent}, 32'd0);
            checkOutput("reset busy", {31'd0, busy}, 32'd0);
        end
        RESET      = 1'b1;
        in_valid   = 1'b0;
        manual_txe = 1'b1;
        #1;
        checkOutput("in_ready before first edge", {31'd0, in_ready}, 32'd0);
        @(negedge CLK);
        checkOutput("in_ready after first edge", {31'd0, in_ready}, 32'd1);
        checkOutput("busy after release", {31'd0, busy}, 32'd0);
        rx_auto = 1'b1;
        repeat (3) @(negedge CLK);

        // Test 2: single token
        log_q.delete();
        applyStimulus(1'b1);
        waitIdle();
        checkOutput("single token count", log_q.size(), 32'd1);
        got = (log_q.size() > 0) ? log_q[0] : 2'b11;
        checkOutput("single token rail", {30'd0, got}, 32'h2);
        checkOutput("single tok_sent", {16'd0, tok_sent}, 32'd1);
        checkOutput("single busy end", {31'd0, busy}, 32'd0);
        checkOutput("single Tx end", {30'd0, Tx}, 32'd0);

        // Test 3: back-to-back stream
        log_q.delete();
        for (int i = 0; i < 8; i++) applyStimulus(stream_bits[i]);
        waitIdle();
        checkOutput("stream token count", log_q.size(), 32'd8);
        for (int i = 0; i < 8; i++) begin
            got = (i < log_q.size()) ? log_q[i] : 2'b11;
            checkOutput($sformatf("stream rail %0d", i), {30'd0, got}, {30'd0, stream_rails[i]});
        end
        checkOutput("stream tok_sent", {16'd0, tok_sent}, 32'd9);

        // Test 4: fill the FIFO with the receiver stalled, then drain
        rx_auto    = 1'b0;
        manual_txe = 1'b0;
        repeat (4) @(negedge CLK);
        log_q.delete();
        for (int i = 0; i < DEPTH; i++) applyStimulus(full_bits[i]);
        checkOutput("full in_ready", {31'd0, in_ready}, 32'd0);
        checkOutput("full Tx neutral", {30'd0, Tx}, 32'd0);
        in_valid = 1'b1;
        in_data  = full_bits[DEPTH];
        repeat (5) begin
            @(negedge CLK);
            checkOutput("full hold in_ready", {31'd0, in_ready}, 32'd0);
        end
        rx_auto = 1'b1;
        for (int i = DEPTH; i < DEPTH + 3; i++) applyStimulus(full_bits[i]);
        waitIdle();
        checkOutput("full token count", log_q.size(), 32'd11);
        for (int i = 0; i < DEPTH + 3; i++) begin
            got = (i < log_q.size()) ? log_q[i] : 2'b11;
            checkOutput($sformatf("full rail %0d", i), {30'd0, got}, {30'd0, full_rails[i]});
        end
        checkOutput("full tok_sent", {16'd0, tok_sent}, 32'd20);

        // Test 5: data queued while the receiver holds Txe low in IDLE
        rx_auto    = 1'b0;
        manual_txe = 1'b0;
        repeat (4) @(negedge CLK);
        log_q.delete();
        applyStimulus(1'b0);
        leak = 0;
        repeat (50) begin
            @(negedge CLK);
            if (Tx != 2'b00) leak++;
        end
        checkOutput("stall Tx neutral", leak, 32'd0);
        manual_txe = 1'b1;
        edges = 0;
        while (Tx == 2'b00 && edges < 20) begin
            @(negedge CLK);
            edges++;
        end
        checkOutput("stall launch edges", edges, SYNC_STAGES + 1);
        checkOutput("stall launch rail", {30'd0, Tx}, 32'h1);
        rx_auto = 1'b1;
        waitIdle();
        checkOutput("stall tok_sent", {16'd0, tok_sent}, 32'd21);
        checkOutput("stall token count", log_q.size(), 32'd1);

        // Test 6: reset while a zero token is on the rails
        rx_auto    = 1'b0;
        manual_txe = 1'b1;
        applyStimulus(1'b0);
        applyStimulus(1'b1);
        applyStimulus(1'b1);
        n = 0;
        while (Tx != 2'b01 && n < 50) begin
            @(negedge CLK);
            n++;
        end
        checkOutput("midreset Tx before", {30'd0, Tx}, 32'h1);
        RESET = 1'b0;
        #1;
        checkOutput("midreset Tx", {30'd0, Tx}, 32'd0);
        checkOutput("midreset tok_sent", {16'd0, tok_sent}, 32'd0);
        checkOutput("midreset busy", {31'd0, busy}, 32'd0);
        checkOutput("midreset in_ready", {31'd0, in_ready}, 32'd0);
        @(negedge CLK);
        RESET = 1'b1;
        repeat (2) @(negedge CLK);
        checkOutput("after reset queue empty", {31'd0, busy}, 32'd0);
        rx_auto = 1'b1;
        repeat (3) @(negedge CLK);
        base = log_q.size();
        applyStimulus(1'b1);
        waitIdle();
        checkOutput("post-reset token count", log_q.size(), base + 1);
        got = (log_q.size() > 0) ? log_q[log_q.size() - 1] : 2'b11;
        checkOutput("post-reset rail", {30'd0, got}, 32'h2);
        checkOutput("post-reset tok_sent", {16'd0, tok_sent}, 32'd1);

        checkOutput("no 2'b11 seen", illegal_cnt, 32'd0);
        checkOutput("neutral between tokens", skip_cnt, 32'd0);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
